urt_rx_cfg: RTL and testbench
=============================

URT_RX_CFG -- requirements
Module: urt_rx_cfg

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data bits per frame, legal 5..9.
REQ-002 Parameter PRESCALE_WIDTH, default 6: width of Prescale.
REQ-003 CLK  input  1  sole clock; all logic on rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 RX_IN  input  1  serial line, asynchronous to CLK, idle high.
REQ-006 PAR_EN  input  1  1 = parity bit present after data.
REQ-007 PAR_TYP  input  1  0 = even, 1 = odd parity.
REQ-008 STP_2  input  1  1 = two stop bits expected.
REQ-009 Prescale  input  PRESCALE_WIDTH  CLK cycles per bit, legal 4..2^PRESCALE_WIDTH-1.
REQ-010 data_ready  input  1  consumer accepts P_DATA.
REQ-011 P_DATA  output  DATA_WIDTH  received word, LSB first on line.
REQ-012 data_valid  output  1  P_DATA holds an unaccepted word.
REQ-013 par_err  output  1  one-cycle pulse, parity mismatch.
REQ-014 stp_err  output  1  one-cycle pulse, stop bit sampled 0.
REQ-015 overrun  output  1  one-cycle pulse, good frame dropped because data_valid still held.

Function
REQ-016 RX_IN SHALL pass a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rx_s.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-018 IDLE: rx_s==0 -> START; edge_cnt=0 on first START cycle; PAR_EN, PAR_TYP, STP_2, Prescale latched on that transition and used for the whole frame.
REQ-019 Prescale latched below 4 SHALL be treated as 4.
REQ-020 Per bit: edge_cnt counts 0..P-1 (P = latched prescale), wraps to 0 and advances to next bit.
REQ-021 Bit value SHALL be majority of rx_s at edge_cnt = P/2-1, P/2, P/2+1 (P/2 truncated); value is available the cycle after the third sample.
REQ-022 START: majority 1 -> glitch, return to IDLE immediately after the third sample, no flags, no output.
REQ-023 DATA: DATA_WIDTH bits, bit counter 0..DATA_WIDTH-1, shifted in LSB first.
REQ-024 PARITY entered only if latched PAR_EN; expected bit = XOR(data) for even, ~XOR(data) for odd.
REQ-025 STOP1 (and STOP2 if latched STP_2) SHALL evaluate after the third sample, not at bit end, so the next start edge can be detected.
REQ-026 Frame completion = cycle after final stop bit's third sample; FSM returns to IDLE same cycle.
REQ-027 On completion any stop sampled 0 -> stp_err pulse; parity mismatch -> par_err pulse; both may pulse together; errored frames SHALL NOT update P_DATA or data_valid.
REQ-028 Good frame, data_valid==0 or (data_valid && data_ready) this cycle: P_DATA loaded, data_valid=1 next cycle.
REQ-029 Good frame, data_valid==1 and data_ready==0: overrun pulse, P_DATA and data_valid unchanged.
REQ-030 data_valid && data_ready with no completion: data_valid=0 next cycle; P_DATA retains value.
REQ-031 data_ready while data_valid==0 SHALL have no effect.
REQ-032 Error and overrun checks are independent of data_ready; errored frame never causes overrun.

Reset
REQ-033 RST low, any state: FSM=IDLE, counters=0, sync flops=1, P_DATA=0, data_valid=0, par_err=stp_err=overrun=0.
REQ-034 Reset mid-frame SHALL discard the partial frame; after release a new frame needs a fresh falling edge.

Verification
REQ-035 Prescale=8, PAR_EN=0, STP_2=0, frame 0xA5 -> data_valid=1, P_DATA=0xA5, no flags; data_ready=1 one cycle -> data_valid=0.
REQ-036 Prescale=16, PAR_EN=1, PAR_TYP=0, data 0x03, parity bit 1 -> par_err one pulse, data_valid stays 0.
REQ-037 Prescale=8, RX_IN low 2 cycles then high -> back to IDLE, no output/flags; next valid frame 0x3C received correctly.
REQ-038 STP_2=1, data 0x81, second stop 0 -> stp_err pulse, no data_valid; second stop 1 -> P_DATA=0x81.
REQ-039 data_ready=0, frames 0x11 then 0x22 -> P_DATA=0x11, overrun pulse at second completion; repeat with data_ready=1 at second completion -> P_DATA=0x22, no overrun.
REQ-040 RST low mid-DATA of 0x55, release, send 0x7E -> all outputs 0 during reset, then P_DATA=0x7E only.

Source files
------------

// File: rtl/urt_rx_cfg.sv
// urt_rx_cfg: configurable UART receiver.
// Oversampled majority-vote bit recovery, optional parity, one or two stop
// bits, and a valid/ready output register that flags words lost to overrun.
module urt_rx_cfg #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STP_2,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      data_ready,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err,
  output logic                      overrun
);

  localparam int PW = PRESCALE_WIDTH;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic                  rx_meta, rx_s;
  logic [PW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [PW-1:0]         presc_q;
  logic                  par_en_q, par_typ_q, stp2_q;
  logic                  samp1_q, samp2_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_bad_q, stop1_bad_q;

  logic [PW-1:0]         half;
  logic                  samp_a, samp_b, samp_c, bit_end, last_bit, maj;
  logic                  done, stop_bad, par_bad, frame_ok, frame_start;

  // Bring the asynchronous line into the CLK domain; idle level is high.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours regardless of order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
    end
  end

  // Sample points inside one bit period: P/2-1, P/2, P/2+1; end at P-1.
  assign half     = presc_q >> 1;
  assign samp_a   = (state != IDLE) && (edge_cnt == half - PW'(1));
  assign samp_b   = (state != IDLE) && (edge_cnt == half);
  assign samp_c   = (state != IDLE) && (edge_cnt == half + PW'(1));
  assign bit_end  = (state != IDLE) && (edge_cnt == presc_q - PW'(1));
  assign last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));
  // Majority of the two stored samples and the live third one.
  assign maj      = (samp1_q & samp2_q) | (samp1_q & rx_s) | (samp2_q & rx_s);

  assign frame_start = (state == IDLE) && !rx_s;
  assign stop_bad    = !maj || ((state == STOP2) && stop1_bad_q);
  assign par_bad     = par_en_q && par_bad_q;
  assign frame_ok    = done && !stop_bad && !par_bad;

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode; a frame completes on the final stop bit's third sample.
  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    unique case (state)
      IDLE:   if (!rx_s) state_nxt = START;
      START: begin
        if (samp_c && maj) state_nxt = IDLE;
        else if (bit_end)  state_nxt = DATA;
      end
      DATA:   if (bit_end && last_bit) state_nxt = par_en_q ? PARITY : STOP1;
      PARITY: if (bit_end) state_nxt = STOP1;
      STOP1: begin
        if (samp_c && !stp2_q) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end else if (bit_end && stp2_q) begin
          state_nxt = STOP2;
        end
      end
      STOP2: begin
        if (samp_c) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timing, frame configuration capture and data/parity/stop recovery.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      presc_q     <= PW'(4);
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      stp2_q      <= 1'b0;
      samp1_q     <= 1'b1;
      samp2_q     <= 1'b1;
      shift_q     <= '0;
      par_bad_q   <= 1'b0;
      stop1_bad_q <= 1'b0;
    end else begin
      if (state == IDLE || state_nxt == IDLE || bit_end) edge_cnt <= '0;
      else                                               edge_cnt <= edge_cnt + PW'(1);

      if (state != DATA)  bit_cnt <= '0;
      else if (bit_end)   bit_cnt <= bit_cnt + BW'(1);

      // Configuration is frozen for the whole frame; prescale floors at 4.
      if (frame_start) begin
        presc_q     <= (Prescale < PW'(4)) ? PW'(4) : Prescale;
        par_en_q    <= PAR_EN;
        par_typ_q   <= PAR_TYP;
        stp2_q      <= STP_2;
        par_bad_q   <= 1'b0;
        stop1_bad_q <= 1'b0;
      end

      if (samp_a) samp1_q <= rx_s;
      if (samp_b) samp2_q <= rx_s;

      if (state == DATA && samp_c)
        shift_q <= {maj, shift_q[DATA_WIDTH-1:1]};
      // Even parity expects XOR(data); odd expects its complement.
      if (state == PARITY && samp_c)
        par_bad_q <= maj ^ (^shift_q) ^ par_typ_q;
      if (state == STOP1 && samp_c && stp2_q)
        stop1_bad_q <= !maj;
    end
  end

  // Output register: error pulses, word hand-off and overrun detection.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      par_err <= done && par_bad;
      stp_err <= done && stop_bad;
      overrun <= 1'b0;
      if (frame_ok && (!data_valid || data_ready)) begin
        P_DATA     <= shift_q;
        data_valid <= 1'b1;
      end else if (frame_ok) begin
        overrun <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_urt_rx_cfg.sv
// Self-checking bench for urt_rx_cfg: a negedge monitor pops an expected-event
// scoreboard filled by the scenario tasks.
`timescale 1ns/1ps
module tb_urt_rx_cfg;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX_IN = 1'b1;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          STP_2 = 1'b0;
  logic [PW-1:0] Prescale = 6'd8;
  logic          data_ready = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          data_valid, par_err, stp_err, overrun;

  typedef enum logic [1:0] {EV_DATA, EV_PAR, EV_STP, EV_OVR} ev_kind_t;
  typedef struct packed {
    ev_kind_t      kind;
    logic [DW-1:0] data;
  } ev_t;

  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic dv_prev  = 1'b0;
  logic rdy_prev = 1'b0;

  urt_rx_cfg #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STP_2      (STP_2),
    .Prescale   (Prescale),
    .data_ready (data_ready),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .overrun    (overrun)
  );

  always #5 CLK = ~CLK;

  // Monitor: every observed event must match the head of the scoreboard.
  // A word load is data_valid rising, or data_valid held across an accept.
  always @(negedge CLK) begin
    ev_t seen[$];
    ev_t e;
    seen = {};
    if (RST) begin
      if (data_valid && (!dv_prev || rdy_prev)) seen.push_back('{EV_DATA, P_DATA});
      if (par_err) seen.push_back('{EV_PAR, '0});
      if (stp_err) seen.push_back('{EV_STP, '0});
      if (overrun) seen.push_back('{EV_OVR, '0});
      foreach (seen[i]) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got kind=%0d data=%h, expected nothing at %0t",
                   seen[i].kind, seen[i].data, $time);
        end else begin
          e = exp_q.pop_front();
          if (seen[i] !== e) begin
            n_fail++;
            $display("FAIL sb_event: got kind=%0d data=%h, expected kind=%0d data=%h at %0t",
                     seen[i].kind, seen[i].data, e.kind, e.data, $time);
          end
        end
      end
    end
    dv_prev  = data_valid;
    rdy_prev = data_ready;
  end

  // Watchdog so the run always ends.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [DW-1:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Drives one frame at the current Prescale. With ready_at_done, data_ready
  // is high exactly on the completion edge (3 sync/entry cycles + h+2).
  task automatic send_frame(input logic [DW-1:0] data, input bit with_par,
                            input logic par_bit, input logic stop1,
                            input bit two_stop, input logic stop2,
                            input bit ready_at_done);
    int p, h;
    p = int'(Prescale);
    if (p < 4) p = 4;
    h = p / 2;
    RX_IN = 1'b0;
    tick(p);
    for (int i = 0; i < DW; i++) begin
      RX_IN = data[i];
      tick(p);
    end
    if (with_par) begin
      RX_IN = par_bit;
      tick(p);
    end
    RX_IN = stop1;
    if (two_stop) begin
      tick(p);
      RX_IN = stop2;
    end
    if (ready_at_done) begin
      tick(h + 4);
      data_ready = 1'b1;
      tick(1);
      data_ready = 1'b0;
      if (p - h - 5 > 0) tick(p - h - 5);
    end else begin
      tick(p);
    end
    RX_IN = 1'b1;
    tick(3 * p);
  endtask

  task automatic accept_word();
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick(3);
    n_checks++; if (P_DATA !== '0)      begin n_fail++; $display("FAIL rst_p_data: got %h expected 00", P_DATA); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_data_valid: got %b expected 0", data_valid); end
    n_checks++; if (par_err !== 1'b0)    begin n_fail++; $display("FAIL rst_par_err: got %b expected 0", par_err); end
    n_checks++; if (stp_err !== 1'b0)    begin n_fail++; $display("FAIL rst_stp_err: got %b expected 0", stp_err); end
    n_checks++; if (overrun !== 1'b0)    begin n_fail++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
    RST = 1'b1;
    tick(4);
  endtask

  task automatic test_basic();
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; STP_2 = 1'b0;
    expect_ev(EV_DATA, 8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++; if (exp_q.size() !== 0)  begin n_fail++; $display("FAIL basic_drain: got %0d pending expected 0", exp_q.size()); end
    n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", data_valid); end
    n_checks++; if (P_DATA !== 8'hA5)    begin n_fail++; $display("FAIL basic_data: got %h expected a5", P_DATA); end
    accept_word();
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_accept: got %b expected 0", data_valid); end
    n_checks++; if (P_DATA !== 8'hA5)    begin n_fail++; $display("FAIL basic_retain: got %h expected a5", P_DATA); end
    data_ready = 1'b1;
    tick(3);
    data_ready = 1'b0;
    tick(1);
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_ready: got %b expected 0", data_valid); end
  endtask

  task automatic test_parity();
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0; STP_2 = 1'b0;
    // 0x03 has even popcount: even parity bit should be 0, 1 is wrong.
    expect_ev(EV_PAR, '0);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL par_even_valid: got %b expected 0", data_valid); end
    // Odd parity for 0x03 is 1: good frame.
    PAR_TYP = 1'b1;
    expect_ev(EV_DATA, 8'h03);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++; if (P_DATA !== 8'h03) begin n_fail++; $display("FAIL par_odd_data: got %h expected 03", P_DATA); end
    accept_word();
    // 0x07 even parity should be 1; send 0 plus a bad stop: both flags.
    PAR_TYP = 1'b0;
    expect_ev(EV_PAR, '0);
    expect_ev(EV_STP, '0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL par_both_valid: got %b expected 0", data_valid); end
    n_checks++; if (exp_q.size() !== 0)  begin n_fail++; $display("FAIL par_drain: got %0d pending expected 0", exp_q.size()); end
    PAR_EN = 1'b0;
  endtask

  task automatic test_glitch();
    Prescale = 6'd8;
    RX_IN = 1'b0;
    tick(2);
    RX_IN = 1'b1;
    tick(32);
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b expected 0", data_valid); end
    expect_ev(EV_DATA, 8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++; if (P_DATA !== 8'h3C)   begin n_fail++; $display("FAIL glitch_next_data: got %h expected 3c", P_DATA); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL glitch_drain: got %0d pending expected 0", exp_q.size()); end
    accept_word();
  endtask

  task automatic test_stop2();
    Prescale = 6'd8; STP_2 = 1'b1;
    expect_ev(EV_STP, '0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL stop2_bad_valid: got %b expected 0", data_valid); end
    expect_ev(EV_DATA, 8'h81);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++; if (P_DATA !== 8'h81)   begin n_fail++; $display("FAIL stop2_good_data: got %h expected 81", P_DATA); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL stop2_drain: got %0d pending expected 0", exp_q.size()); end
    accept_word();
    STP_2 = 1'b0;
  endtask

  task automatic test_back_to_back();
    Prescale = 6'd8;
    expect_ev(EV_DATA, 8'h11);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_ev(EV_OVR, '0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++; if (P_DATA !== 8'h11)    begin n_fail++; $display("FAIL ovr_data_kept: got %h expected 11", P_DATA); end
    n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_kept: got %b expected 1", data_valid); end
    accept_word();
    expect_ev(EV_DATA, 8'h11);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_ev(EV_DATA, 8'h22);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    n_checks++; if (P_DATA !== 8'h22)    begin n_fail++; $display("FAIL b2b_data: got %h expected 22", P_DATA); end
    n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b expected 1", data_valid); end
    n_checks++; if (exp_q.size() !== 0)  begin n_fail++; $display("FAIL b2b_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  // Enters with data_valid=1 holding 0x22; reset must clear it.
  task automatic test_reset_mid();
    logic [DW-1:0] partial;
    partial  = 8'h55;
    Prescale = 6'd8;
    RX_IN = 1'b0;
    tick(8);
    for (int i = 0; i < 3; i++) begin
      RX_IN = partial[i];
      tick(8);
    end
    RST = 1'b0;
    tick(1);
    n_checks++; if (P_DATA !== '0)       begin n_fail++; $display("FAIL mid_rst_p_data: got %h expected 00", P_DATA); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", data_valid); end
    n_checks++; if ({par_err, stp_err, overrun} !== 3'b000) begin
      n_fail++; $display("FAIL mid_rst_flags: got %b expected 000", {par_err, stp_err, overrun});
    end
    RX_IN = 1'b1;
    tick(4);
    RST = 1'b1;
    tick(40);
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL mid_post_valid: got %b expected 0", data_valid); end
    expect_ev(EV_DATA, 8'h7E);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++; if (P_DATA !== 8'h7E)   begin n_fail++; $display("FAIL mid_new_data: got %h expected 7e", P_DATA); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL mid_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_stop2();
    test_back_to_back();
    test_reset_mid();
    tick(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
